// File: rtl/window_serializer.sv
// Parallel-in, serial-out window transmitter: loads up to SHIFT_DEPTH words in one
// handshake and emits one word per accepted beat. Optional macro: WINDOW_SERIALIZER_REVERSE_EN.
module window_serializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH*SHIFT_DEPTH-1:0] par_in,
    input  logic [$clog2(SHIFT_DEPTH+1)-1:0]  load_len,
    input  logic                              par_valid,
    output logic                              par_ready,
    output logic [DATA_WIDTH-1:0]             serial_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy
);

    localparam int LEN_W = $clog2(SHIFT_DEPTH + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_buf      [SHIFT_DEPTH];
    logic [DATA_WIDTH-1:0] w_load_buf [SHIFT_DEPTH];
    logic [LEN_W-1:0]      r_cnt;
    logic [LEN_W-1:0]      w_len;
    logic                  w_last;
    logic                  w_beat;
    logic                  w_load;
    logic                  w_load_nz;

    assign w_last     = (r_state == S_SHIFT) && (r_cnt == LEN_W'(1));
    assign out_valid  = (r_state == S_SHIFT);
    assign busy       = (r_state == S_SHIFT);
    assign out_last   = w_last;
    assign serial_out = r_buf[0];

    assign w_beat    = out_valid & out_ready;
    // Ready during the last beat lets the next window follow with no idle cycle.
    assign par_ready = (r_state == S_IDLE) | (w_beat & w_last);
    assign w_load    = par_valid & par_ready;
    assign w_len     = (load_len > LEN_W'(SHIFT_DEPTH)) ? LEN_W'(SHIFT_DEPTH) : load_len;
    assign w_load_nz = w_load & (w_len != LEN_W'(0));

    // Arrange the incoming window into buffer order (word to emit first in slot 0).
    always_comb begin
        for (int i = 0; i < SHIFT_DEPTH; i++) begin
            w_load_buf[i] = '0;
`ifdef WINDOW_SERIALIZER_REVERSE_EN
            if (i < int'(w_len)) begin
                w_load_buf[i] = par_in[(int'(w_len) - 1 - i)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_load_buf[i] = '0;
            end
`else
            w_load_buf[i] = par_in[i*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end

    // Next-state logic; a zero-length load never starts a window.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load_nz) begin
                    w_next_state = S_SHIFT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_beat && w_last) begin
                    w_next_state = w_load_nz ? S_SHIFT : S_IDLE;
                end else begin
                    w_next_state = S_SHIFT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Buffer and remaining-word count: load has priority over the shift of a last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            for (int i = 0; i < SHIFT_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_load_nz) begin
            r_cnt <= w_len;
            for (int i = 0; i < SHIFT_DEPTH; i++) begin
                r_buf[i] <= w_load_buf[i];
            end
        end else if (w_beat) begin
            r_cnt <= r_cnt - LEN_W'(1);
            for (int i = 0; i < SHIFT_DEPTH - 1; i++) begin
                r_buf[i] <= r_buf[i+1];
            end
            r_buf[SHIFT_DEPTH-1] <= '0;
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: tb/tb_window_serializer.sv
// Self-checking bench for window_serializer: directed scenarios then random traffic,
// checked against a queue-based model of the expected outgoing word stream.
module tb_window_serializer;

    localparam int DW = 16;
    localparam int SD = 8;
    localparam int LW = $clog2(SD + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [DW*SD-1:0] par_in;
    logic [LW-1:0]    load_len;
    logic             par_valid;
    logic             par_ready;
    logic [DW-1:0]    serial_out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    int            n_asserts = 0;
    int            n_fail    = 0;
    int            dut_beats = 0;
    int            b0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] dl[SD];
    logic [DW-1:0] exp_word;

    window_serializer #(.DATA_WIDTH(DW), .SHIFT_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .par_in(par_in), .load_len(load_len),
        .par_valid(par_valid), .par_ready(par_ready), .serial_out(serial_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW*SD-1:0] mk(input int base);
        logic [DW*SD-1:0] w;
        for (int i = 0; i < SD; i++) w[i*DW +: DW] = DW'(base + i);
        return w;
    endfunction

    // One cycle: compare outputs with the model, advance the model, move to next negedge.
    task automatic tick();
        bit ev, el, er, beat, load;
        int len;
        #1;
        ev = (q.size() > 0);
        el = (q.size() == 1);
        er = !ev || (out_ready && el);
        if (!rst) begin
            check("out_valid", out_valid, ev);
            check("busy", busy, ev);
            check("par_ready", par_ready, er);
            check("out_last", out_last, ev && el);
            if (ev) check("serial_out", serial_out, q[0]);
            if (out_valid && out_ready) begin
                dut_beats++;
                for (int i = SD - 1; i > 0; i--) dl[i] = dl[i-1];
                dl[0] = serial_out;
            end
        end
        beat = ev && out_ready;
        load = par_valid && er;
        if (rst) begin
            q.delete();
        end else begin
            if (beat) void'(q.pop_front());
            if (load) begin
                len = (int'(load_len) > SD) ? SD : int'(load_len);
                for (int k = 0; k < len; k++) begin
`ifdef WINDOW_SERIALIZER_REVERSE_EN
                    q.push_back(par_in[(len-1-k)*DW +: DW]);
`else
                    q.push_back(par_in[k*DW +: DW]);
`endif
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic present(input logic [DW*SD-1:0] w, input int len);
        par_in    = w;
        load_len  = LW'(len);
        par_valid = 1'b1;
    endtask

    initial begin
        int rdy_seq[5];
        rdy_seq = '{1, 0, 0, 1, 1};
        for (int i = 0; i < SD; i++) dl[i] = '0;
        rst = 1'b1; par_valid = 1'b0; out_ready = 1'b1; par_in = '0; load_len = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_par_ready", par_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_serial_out", serial_out, 16'h0000);
        tick();

        // Full window of 8 words, no backpressure.
        b0 = dut_beats;
        present(mk(1), 8);
        tick();
        par_valid = 1'b0;
        repeat (9) tick();
        check("full_beats", dut_beats - b0, 8);
`ifdef WINDOW_SERIALIZER_REVERSE_EN
        exp_word = 16'h0008;
`else
        exp_word = 16'h0001;
`endif
        check("full_depth7", dl[SD-1], exp_word);

        // Backpressure on the middle word.
        b0 = dut_beats;
        present(mk('hA0), 3);
        tick();
        par_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            out_ready = rdy_seq[i][0];
            if (rdy_seq[i] == 0) begin
                #1;
                check("bp_hold", serial_out, 16'h00A1);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_beats", dut_beats - b0, 3);

        // Zero-bubble back-to-back windows.
        present(mk('hC0), 2);
        tick();
        par_valid = 1'b0;
        tick();
        present(mk('hB0), 2);
        #1;
        check("zb_par_ready", par_ready, 1'b1);
        tick();
        par_valid = 1'b0;
        #1;
`ifdef WINDOW_SERIALIZER_REVERSE_EN
        exp_word = 16'h00B1;
`else
        exp_word = 16'h00B0;
`endif
        check("zb_out_valid", out_valid, 1'b1);
        check("zb_first_word", serial_out, exp_word);
        repeat (3) tick();

        // Edge lengths: 0, 1 and an over-range value.
        b0 = dut_beats;
        present(mk('h50), 0);
        tick();
        par_valid = 1'b0;
        #1;
        check("len0_out_valid", out_valid, 1'b0);
        check("len0_par_ready", par_ready, 1'b1);
        tick();
        check("len0_beats", dut_beats - b0, 0);
        present(mk('h55), 1);
        tick();
        par_valid = 1'b0;
        #1;
        check("len1_last", out_last, 1'b1);
        check("len1_word", serial_out, 16'h0055);
        repeat (2) tick();
        b0 = dut_beats;
        present(mk('h60), 15);
        tick();
        par_valid = 1'b0;
        repeat (10) tick();
        check("len15_clamped", dut_beats - b0, 8);

        // Reset in the middle of a window.
        present(mk('h70), 5);
        tick();
        par_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        b0 = dut_beats;
        repeat (4) tick();
        check("midrst_no_beats", dut_beats - b0, 0);

        // Four-word window (reversed emission when the option is built in).
        present(mk(1), 4);
        tick();
        par_valid = 1'b0;
        repeat (5) tick();

        // Random traffic.
        repeat (400) begin
            par_valid = ($urandom_range(0, 1) == 1);
            load_len  = LW'($urandom_range(0, 15));
            par_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; par_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
